// File: rtl/fdiv_share_ctrl_if.sv
// Request, response and divider-core signal bundle for the shared divider controller.
interface fdiv_share_ctrl_if #(
    parameter int unsigned NREQ = 4
);
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [32*NREQ-1:0] req_a;
    logic [32*NREQ-1:0] req_b;

    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [31:0]        rsp_z;

    logic               div_start;
    logic [31:0]        div_a;
    logic [31:0]        div_b;
    logic [31:0]        div_z;

    // Controller side
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, div_z,
        output req_ready, rsp_valid, rsp_id, rsp_z, div_start, div_a, div_b
    );

    // Requesters, response consumer and divider core side
    modport master (
        output req_valid, req_a, req_b, rsp_ready, div_z,
        input  req_ready, rsp_valid, rsp_id, rsp_z, div_start, div_a, div_b
    );
endinterface

// File: rtl/fdiv_share_ctrl.sv
// Round-robin sharing and sequencing controller for one iterative FP divider core.
module fdiv_share_ctrl #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned ITER = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    fdiv_share_ctrl_if.slave     bus,
    output logic                 busy
);
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  id_q;
    logic [CW-1:0]   cnt;
    logic [31:0]     a_q;
    logic [31:0]     b_q;
    logic [31:0]     z_q;
    logic            rsp_valid_q;
    logic            div_start_q;
    logic            busy_q;

    logic            grant_vld;
    logic [IDW-1:0]  grant_id;
    logic [31:0]     grant_a;
    logic [31:0]     grant_b;
    logic [NREQ-1:0] req_ready_c;

    // First valid requester at or above ptr, wrapping modulo NREQ
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        grant_a   = '0;
        grant_b   = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            for (int unsigned j = 0; j < NREQ; j++) begin
                if (!grant_vld && bus.req_valid[j] && (((32'(ptr) + off) % NREQ) == j)) begin
                    grant_vld = 1'b1;
                    grant_id  = IDW'(j);
                    grant_a   = bus.req_a[32*j +: 32];
                    grant_b   = bus.req_b[32*j +: 32];
                end
            end
        end
    end

    // Accept is combinational in IDLE so the handshake completes in the grant cycle
    always_comb begin
        req_ready_c = '0;
        if (rst && (state == IDLE) && grant_vld) begin
            req_ready_c[grant_id] = 1'b1;
        end
    end

    // Sequencer: grant, start pulse, iteration wait, response hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            ptr         <= '0;
            id_q        <= '0;
            cnt         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            z_q         <= '0;
            rsp_valid_q <= 1'b0;
            div_start_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        a_q         <= grant_a;
                        b_q         <= grant_b;
                        id_q        <= grant_id;
                        div_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state       <= START;
                    end
                end
                START: begin
                    div_start_q <= 1'b0;
                    cnt         <= CW'(ITER - 1);
                    state       <= WAIT;
                end
                WAIT: begin
                    if (cnt == '0) begin
                        z_q         <= bus.div_z;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        ptr         <= (32'(id_q) == (NREQ - 1)) ? '0 : id_q + 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_z     = z_q;
    assign bus.div_start = div_start_q;
    assign bus.div_a     = a_q;
    assign bus.div_b     = b_q;
    assign busy          = busy_q;

endmodule

// File: doc/fdiv_share_ctrl.md
# fdiv_share_ctrl

Sequencing and round-robin sharing controller for the single iterative single-precision floating-point divider core. It accepts divide requests from NREQ independent requesters and grants one at a time. It drives the core's operands and start pulse, waits the core's fixed iteration latency, then returns the quotient with the requester's index on one response channel. It sits between the requesting units and the divider core; the core itself is unchanged.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8); IDW = clog2(NREQ) is derived, minimum 1
- ITER, 4, cycles from the core's start cycle to a valid quotient on div_z (1..15)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; at most one bit high (one-hot or zero)
- req_a  in  32*NREQ  dividends, requester i at [32*i+31:32*i]
- req_b  in  32*NREQ  divisors, same packing
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  IDW  index of requester owning the response
- rsp_z  out  32  quotient (IEEE-754 single)
- busy  out  1  high in every state except IDLE
- div_start  out  1  one-cycle start pulse to the core
- div_a  out  32  dividend to the core
- div_b  out  32  divisor to the core
- div_z  in  32  core result

## Operation
- FSM states: IDLE, START, WAIT, RESP.
- IDLE: if any req_valid is high, grant the first valid index searching upward from ptr, wrapping modulo NREQ. req_ready[grant] is high combinationally this cycle, so the handshake completes now. Latch req_a/req_b of the grant into the operand registers and the index into id_q. Go to START. If no request is valid, all req_ready bits are 0 and the FSM stays in IDLE.
- START: div_start=1 for exactly this cycle. Load cnt=ITER-1. Go to WAIT.
- WAIT: decrement cnt each cycle. When cnt==0, capture div_z into rsp_z and go to RESP.
- RESP: rsp_valid=1 and rsp_id=id_q. rsp_z and rsp_id are held stable until the handshake. When rsp_ready=1: set ptr=(id_q+1) mod NREQ and go to IDLE.
- div_a and div_b are driven from the operand registers. They stay stable from START through the end of RESP and change only on a new grant.
- req_ready is 0 in START, WAIT and RESP. Requests arriving in those states wait and are not dropped. A requester that drops req_valid before it is granted is simply skipped.
- Requester-side rule: a requester holds req_valid, req_a and req_b stable until its req_ready is seen.
- The controller does not interpret operands: NaN, Inf, zero and subnormal cases are resolved by the core, and div_z is forwarded bit-exact.
- Fairness: after requester k is served, ptr=k+1. With all requesters valid, service order is 0,1,…,NREQ-1,0,…

## Timing
- Reset (rst=0, asynchronous) values:
  - FSM=IDLE, ptr=0, cnt=0, id_q=0.
  - Operand registers and rsp_z are 0.
  - rsp_valid=0, div_start=0, busy=0, req_ready=0.
- Reset mid-operation abandons the in-flight divide with no response. After reset release, the first accept is allowed in the first cycle with rst=1.
- Latency, with accept in cycle T:
  - div_start is high in T+1.
  - div_z is sampled in T+1+ITER.
  - rsp_valid is high from T+2+ITER.
- If rsp_ready is already high at T+2+ITER: FSM is IDLE in T+3+ITER and the next accept can happen that same cycle. Maximum throughput is one divide per ITER+3 cycles.
- rsp_ready low stalls RESP indefinitely. No new request is accepted during the stall.
- If a req_valid rises in the same cycle the FSM leaves RESP, it is arbitrated in the next cycle (IDLE).
- cnt width is 4 bits. ITER=1 means START is followed by exactly one WAIT cycle.

## Test plan
- Single request: req0 sends a=0x40C00000, b=0x40000000, and the core model returns the quotient ITER cycles after start. Required: req_ready[0] high in T; div_start high only in T+1; rsp_valid high in T+6 with rsp_z=0x40400000 and rsp_id=0 (ITER=4).
- Round-robin: all four requesters held valid with distinct operands. Required: grant order 0,1,2,3,0; each rsp_id matches its operands; one request completes per 7 cycles with rsp_ready tied high.
- Backpressure: rsp_ready=0 for 10 cycles in RESP while req1 is valid. Required: rsp_z and rsp_id stay stable, req_ready stays 0, and req1 is accepted the cycle after the rsp handshake plus the return to IDLE.
- Special values pass-through: a=0x7F800000, b=0x00000000. Required: rsp_z equals the core model output 0x7F800000 bit-exact, and div_a/div_b are stable through RESP.
- Reset mid-WAIT: assert rst=0 two cycles after div_start. Required: rsp_valid, busy and div_start go to 0 immediately, with no response afterwards; ptr=0, so req3 and req0 both valid after release grants req0.
- Skip dropped request: ptr=2, req2 withdraws, req3 is valid. Required: req3 is granted and ptr becomes 0 after its response.
